// File: rtl/rr_gnt_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_gnt_arbiter_if
// Description : Request/grant bundle between requesters and the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_gnt_arbiter_if #(
    parameter int N = 4
);
    localparam int C_IDW = $clog2(N);

    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic             gnt_valid;
    logic [C_IDW-1:0] gnt_id;

    // master: the arbiter, which sources the grant; slave: the requester side
    modport master (input req, output gnt, output gnt_valid, output gnt_id);
    modport slave  (output req, input gnt, input gnt_valid, input gnt_id);
endinterface
`default_nettype wire

// File: rtl/rr_gnt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_gnt_arbiter
// Description : Round-robin arbiter with a per-grant hold limit and rotating
//               priority; registered one-hot grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_gnt_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  wire              clk,
    input  wire              rstn,
    rr_gnt_arbiter_if.master bus
);
    localparam int               C_IDW       = $clog2(N);
    localparam int               C_HCW       = $clog2(MAX_HOLD + 1);
    localparam logic [C_IDW-1:0] C_LAST_ID   = C_IDW'(N - 1);
    localparam logic [C_HCW-1:0] C_HOLD_LAST = C_HCW'(MAX_HOLD - 1);
    localparam logic [N-1:0]     C_ONE       = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t           r_state;
    logic [C_IDW-1:0] r_ptr;
    logic [C_IDW-1:0] r_gnt_id;
    logic [C_HCW-1:0] r_hold_cnt;
    logic [N-1:0]     r_gnt;
    logic             r_gnt_valid;

    logic [C_IDW-1:0] w_next_ptr;
    logic [C_IDW-1:0] w_start;
    logic [C_IDW-1:0] w_idx;
    logic [C_IDW-1:0] w_win;
    logic             w_found;
    logic             w_release;

    // Wrap compares against N-1 so non-power-of-two N works
    assign w_next_ptr = (r_gnt_id == C_LAST_ID) ? '0 : r_gnt_id + C_IDW'(1);
    assign w_start    = (r_state == S_GRANT) ? w_next_ptr : r_ptr;
    assign w_release  = !bus.req[r_gnt_id] || (r_hold_cnt == C_HOLD_LAST);

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = w_start;
        for (int i = 0; i < N; i++) begin
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
            w_idx = (w_idx == C_LAST_ID) ? '0 : w_idx + C_IDW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_gnt_id    <= '0;
            r_hold_cnt  <= '0;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt       <= C_ONE << w_win;
                        r_gnt_id    <= w_win;
                        r_gnt_valid <= 1'b1;
                        r_hold_cnt  <= '0;
                        r_state     <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        r_ptr      <= w_next_ptr;
                        r_hold_cnt <= '0;
                        // Hand over directly to the next owner: no idle bubble
                        if (w_found) begin
                            r_gnt    <= C_ONE << w_win;
                            r_gnt_id <= w_win;
                        end else begin
                            r_gnt       <= '0;
                            r_gnt_valid <= 1'b0;
                            r_state     <= S_IDLE;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + C_HCW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.gnt_valid = r_gnt_valid;
    assign bus.gnt_id    = r_gnt_id;
endmodule
`default_nettype wire

// File: tb/tb_rr_gnt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_gnt_arbiter
// Description : Self-checking bench for rr_gnt_arbiter against an owner/queue
//               style reference model; directed scenarios plus random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_gnt_arbiter;
    localparam int NP = 4;
    localparam int MH = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    // Model: current owner (-1 = none), cycles owned so far, scan start, last owner
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    int m_last  = 0;

    rr_gnt_arbiter_if #(.N(NP)) bus ();

    rr_gnt_arbiter #(.N(NP), .MAX_HOLD(MH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int scan(input logic [NP-1:0] r, input int start);
        for (int i = 0; i < NP; i++)
            if (r[(start + i) % NP]) return (start + i) % NP;
        return -1;
    endfunction

    function automatic void model_reset();
        m_owner = -1; m_held = 0; m_ptr = 0; m_last = 0;
    endfunction

    function automatic void model_step(input logic [NP-1:0] r);
        int w;
        if (m_owner < 0) begin
            w = scan(r, m_ptr);
            if (w >= 0) begin m_owner = w; m_held = 1; m_last = w; end
        end else if (!r[m_owner] || m_held == MH) begin
            m_ptr = (m_owner + 1) % NP;
            w = scan(r, m_ptr);
            if (w >= 0) begin m_owner = w; m_held = 1; m_last = w; end
            else m_owner = -1;
        end else begin
            m_held++;
        end
    endfunction

    task automatic check_all(input string tag);
        logic [NP-1:0] eg;
        eg = (m_owner < 0) ? '0 : NP'(1 << m_owner);
        chk({tag, ".gnt"},   32'(bus.gnt),        32'(eg));
        chk({tag, ".valid"}, 32'(bus.gnt_valid),  32'(m_owner >= 0));
        chk({tag, ".id"},    32'(bus.gnt_id),     32'(m_last));
        chk({tag, ".hold"},  32'(dut.r_hold_cnt), 32'((m_owner < 0) ? 0 : m_held - 1));
        chk({tag, ".ptr"},   32'(dut.r_ptr),      32'(m_ptr));
    endtask

    task automatic cycle(input string tag, input logic [NP-1:0] r);
        bus.req = r;
        @(posedge clk);
        if (rstn) model_step(r);
        #1;
        check_all(tag);
    endtask

    // Asserts reset between edges, checks the asynchronous clear, then releases
    task automatic apply_reset();
        @(posedge clk);
        #3 rstn = 1'b0;
        model_reset();
        #1 check_all("rst_async");
        bus.req = NP'($urandom);
        @(posedge clk);
        #1 check_all("rst_held");
        #1 rstn = 1'b1;
    endtask

    logic [NP-1:0] r_prev;

    initial begin
        bus.req = 4'hF;
        model_reset();
        // 1: reset ignores requests, then a single requester wins after one edge
        repeat (2) begin
            @(posedge clk);
            #1 check_all("t1_rst");
        end
        #1 rstn = 1'b1;
        cycle("t1", 4'b0100);
        chk("t1_gnt", 32'(bus.gnt), 32'h4);
        chk("t1_id",  32'(bus.gnt_id), 32'd2);

        // 2: full load rotates every MH cycles without gaps
        apply_reset();
        for (int k = 0; k < 20; k++) begin
            cycle("t2", 4'hF);
            chk("t2_pat", 32'(bus.gnt), 32'(1 << ((k / MH) % NP)));
        end

        // 3: early release by owner 0 hands over to 2
        apply_reset();
        cycle("t3", 4'b0101);
        cycle("t3", 4'b0101);
        cycle("t3", 4'b0100);
        chk("t3_gnt", 32'(bus.gnt), 32'h4);
        chk("t3_id",  32'(bus.gnt_id), 32'd2);

        // 4: owner 3 expires, pointer wraps to 0
        apply_reset();
        cycle("t4", 4'b1000);
        for (int k = 0; k < MH; k++) cycle("t4", 4'b1001);
        chk("t4_gnt", 32'(bus.gnt), 32'h1);
        chk("t4_ptr", 32'(dut.r_ptr), 32'd0);
        for (int k = 0; k < MH + 2; k++) cycle("t4", 4'b1001);

        // 5: asynchronous reset while owner 2 is at hold_cnt 2
        apply_reset();
        for (int k = 0; k < 3; k++) cycle("t5", 4'b0100);
        chk("t5_hold", 32'(dut.r_hold_cnt), 32'd2);
        #3 rstn = 1'b0;
        model_reset();
        #1 chk("t5_async_gnt", 32'(bus.gnt), 32'h0);
        check_all("t5_async");
        @(posedge clk);
        #2 rstn = 1'b1;
        cycle("t5", 4'b1010);
        chk("t5_gnt", 32'(bus.gnt), 32'h2);

        // 6: lone requester is re-granted at expiry without a gap
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            cycle("t6", 4'b0010);
            chk("t6_valid", 32'(bus.gnt_valid), 32'd1);
            chk("t6_hold",  32'(dut.r_hold_cnt), 32'(k % MH));
        end

        // Random traffic with sticky/flipped patterns and periodic resets
        r_prev = '0;
        for (int k = 0; k < 450; k++) begin
            logic [NP-1:0] r;
            case ($urandom_range(0, 3))
                0:       r = NP'($urandom);
                1:       r = r_prev;
                2:       r = r_prev ^ NP'(1 << $urandom_range(0, NP - 1));
                default: r = NP'(1 << $urandom_range(0, NP - 1));
            endcase
            if ($urandom_range(0, 15) == 0) r = '0;
            r_prev = r;
            if (k % 150 == 149) apply_reset();
            cycle("rnd", r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end
endmodule
`default_nettype wire
